// File: rtl/gb10_warp_scheduler.sv
// Round-robin warp scheduler feeding the shared gb10 tensor datapath.
// Each warp slot walks IDLE -> PENDING -> QUEUED -> INFLIGHT -> IDLE; one registered issue port.
module gb10_warp_scheduler #(
    parameter  int WARP_COUNT   = 16,
    parameter  int MAX_INFLIGHT = 4,
    parameter  int CMD_W        = 64,
    localparam int WID_W        = $clog2(WARP_COUNT),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  launch_valid_i,
    input  logic [WID_W-1:0]      launch_warp_i,
    input  logic [CMD_W-1:0]      launch_cmd_i,
    output logic                  launch_err_o,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [WID_W-1:0]      issue_warp_o,
    output logic [CMD_W-1:0]      issue_cmd_o,
    input  logic                  cpl_valid_i,
    input  logic [WID_W-1:0]      cpl_warp_i,
    output logic                  cpl_err_o,
    output logic [WARP_COUNT-1:0] warp_busy_o,
    output logic [CNT_W-1:0]      inflight_cnt_o,
    output logic                  idle_o,
    output logic [31:0]           issue_count_o
);

    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [CNT_W:0] MAX_CNT = CNT_W1'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_PENDING,
        SLOT_QUEUED,
        SLOT_INFLIGHT
    } slot_state_e;

    slot_state_e           state_q [WARP_COUNT];
    slot_state_e           state_d [WARP_COUNT];
    logic [CMD_W-1:0]      cmd_q   [WARP_COUNT];
    logic [CMD_W-1:0]      cmd_d   [WARP_COUNT];

    logic                  issue_valid_q, issue_valid_d;
    logic [WID_W-1:0]      issue_warp_q, issue_warp_d;
    logic [CMD_W-1:0]      issue_cmd_q, issue_cmd_d;
    logic [WID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      inflight_cnt_q, inflight_cnt_d;
    logic [31:0]           issue_count_q, issue_count_d;
    logic                  launch_err_q, launch_err_d;
    logic                  cpl_err_q, cpl_err_d;
    logic [WARP_COUNT-1:0] warp_busy_q, warp_busy_d;
    logic                  idle_q, idle_d;

    logic                  handshake;
    logic                  launch_ok;
    logic                  cpl_ok;
    logic                  sel_found;
    logic [WID_W-1:0]      sel_idx;
    logic [WID_W-1:0]      cand;
    logic                  cap_ok;
    logic                  load;
    logic                  all_idle;

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        issue_valid_d  = issue_valid_q;
        issue_warp_d   = issue_warp_q;
        issue_cmd_d    = issue_cmd_q;
        rr_ptr_d       = rr_ptr_q;
        sel_found      = 1'b0;
        sel_idx        = '0;
        cand           = '0;
        all_idle       = 1'b1;
        warp_busy_d    = '0;

        handshake    = issue_valid_q & issue_ready_i;
        launch_ok    = launch_valid_i && (state_q[launch_warp_i] == SLOT_IDLE);
        launch_err_d = launch_valid_i && !launch_ok;
        cpl_ok       = cpl_valid_i && (state_q[cpl_warp_i] == SLOT_INFLIGHT);
        cpl_err_d    = cpl_valid_i && !cpl_ok;

        // Scan starts just past the last winner; the final step wraps back onto the pointer itself.
        for (int i = 1; i <= WARP_COUNT; i++) begin
            cand = rr_ptr_q + WID_W'(i);
            if (!sel_found && state_q[cand] == SLOT_PENDING) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end

        // Completions only free capacity from the following cycle on.
        cap_ok = ({1'b0, inflight_cnt_q} + CNT_W1'(handshake)) < MAX_CNT;
        load   = (!issue_valid_q || handshake) && sel_found && cap_ok;

        if (handshake) begin
            state_d[issue_warp_q] = SLOT_INFLIGHT;
            issue_valid_d         = 1'b0;
        end

        if (load) begin
            state_d[sel_idx] = SLOT_QUEUED;
            issue_valid_d    = 1'b1;
            issue_warp_d     = sel_idx;
            issue_cmd_d      = cmd_q[sel_idx];
            rr_ptr_d         = sel_idx;
        end

        if (launch_ok) begin
            state_d[launch_warp_i] = SLOT_PENDING;
            cmd_d[launch_warp_i]   = launch_cmd_i;
        end

        if (cpl_ok) begin
            state_d[cpl_warp_i] = SLOT_IDLE;
        end

        inflight_cnt_d = inflight_cnt_q + CNT_W'(handshake) - CNT_W'(cpl_ok);
        issue_count_d  = issue_count_q + 32'(handshake);

        for (int w = 0; w < WARP_COUNT; w++) begin
            warp_busy_d[w] = (state_d[w] != SLOT_IDLE);
            if (state_d[w] != SLOT_IDLE) begin
                all_idle = 1'b0;
            end
        end
        idle_d = all_idle && !issue_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < WARP_COUNT; w++) begin
                state_q[w] <= SLOT_IDLE;
            end
            issue_valid_q  <= 1'b0;
            issue_warp_q   <= '0;
            issue_cmd_q    <= '0;
            rr_ptr_q       <= WID_W'(WARP_COUNT - 1);
            inflight_cnt_q <= '0;
            issue_count_q  <= '0;
            launch_err_q   <= 1'b0;
            cpl_err_q      <= 1'b0;
            warp_busy_q    <= '0;
            idle_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            issue_valid_q  <= issue_valid_d;
            issue_warp_q   <= issue_warp_d;
            issue_cmd_q    <= issue_cmd_d;
            rr_ptr_q       <= rr_ptr_d;
            inflight_cnt_q <= inflight_cnt_d;
            issue_count_q  <= issue_count_d;
            launch_err_q   <= launch_err_d;
            cpl_err_q      <= cpl_err_d;
            warp_busy_q    <= warp_busy_d;
            idle_q         <= idle_d;
        end
    end

    // Command storage needs no reset: a slot's command is only read after a launch wrote it.
    always_ff @(posedge clk_i) begin
        cmd_q <= cmd_d;
    end

    assign launch_err_o   = launch_err_q;
    assign issue_valid_o  = issue_valid_q;
    assign issue_warp_o   = issue_warp_q;
    assign issue_cmd_o    = issue_cmd_q;
    assign cpl_err_o      = cpl_err_q;
    assign warp_busy_o    = warp_busy_q;
    assign inflight_cnt_o = inflight_cnt_q;
    assign idle_o         = idle_q;
    assign issue_count_o  = issue_count_q;

endmodule

// File: tb/tb_gb10_warp_scheduler.sv
// Directed self-checking bench for gb10_warp_scheduler (16 warps, 4 in flight).
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_gb10_warp_scheduler;

    localparam int WARP_COUNT   = 16;
    localparam int MAX_INFLIGHT = 4;
    localparam int CMD_W        = 64;
    localparam int WID_W        = 4;
    localparam int CNT_W        = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  launch_valid_i = 1'b0;
    logic [WID_W-1:0]      launch_warp_i = '0;
    logic [CMD_W-1:0]      launch_cmd_i = '0;
    logic                  launch_err_o;
    logic                  issue_valid_o;
    logic                  issue_ready_i = 1'b0;
    logic [WID_W-1:0]      issue_warp_o;
    logic [CMD_W-1:0]      issue_cmd_o;
    logic                  cpl_valid_i = 1'b0;
    logic [WID_W-1:0]      cpl_warp_i = '0;
    logic                  cpl_err_o;
    logic [WARP_COUNT-1:0] warp_busy_o;
    logic [CNT_W-1:0]      inflight_cnt_o;
    logic                  idle_o;
    logic [31:0]           issue_count_o;

    int n_checks = 0;
    int n_fails  = 0;
    int hs_log[$];

    gb10_warp_scheduler #(
        .WARP_COUNT  (WARP_COUNT),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CMD_W       (CMD_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .launch_valid_i(launch_valid_i),
        .launch_warp_i (launch_warp_i),
        .launch_cmd_i  (launch_cmd_i),
        .launch_err_o  (launch_err_o),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready_i),
        .issue_warp_o  (issue_warp_o),
        .issue_cmd_o   (issue_cmd_o),
        .cpl_valid_i   (cpl_valid_i),
        .cpl_warp_i    (cpl_warp_i),
        .cpl_err_o     (cpl_err_o),
        .warp_busy_o   (warp_busy_o),
        .inflight_cnt_o(inflight_cnt_o),
        .idle_o        (idle_o),
        .issue_count_o (issue_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Record the warp of every handshake that the next rising edge will take.
    always @(negedge clk_i) begin
        if (!rst_i && issue_valid_o && issue_ready_i) begin
            hs_log.push_back(int'(issue_warp_o));
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input bit lv, input int lw, input logic [63:0] lc,
                                 input bit cv, input int cw);
        launch_valid_i = lv;
        launch_warp_i  = WID_W'(lw);
        launch_cmd_i   = lc;
        cpl_valid_i    = cv;
        cpl_warp_i     = WID_W'(cw);
    endtask

    task automatic checkLog(input string tag, input int exp[$]);
        checkOutput({tag, "_len"}, 64'(hs_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < hs_log.size(); i++) begin
            checkOutput($sformatf("%s_%0d", tag, i), 64'(hs_log[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        // Reset values
        step();
        step();
        checkOutput("rst_valid", 64'(issue_valid_o), 64'd0);
        checkOutput("rst_idle", 64'(idle_o), 64'd1);
        checkOutput("rst_busy", 64'(warp_busy_o), 64'd0);
        checkOutput("rst_count", 64'(issue_count_o), 64'd0);
        checkOutput("rst_inflight", 64'(inflight_cnt_o), 64'd0);
        checkOutput("rst_warp", 64'(issue_warp_o), 64'd0);
        checkOutput("rst_cmd", issue_cmd_o, 64'd0);
        checkOutput("rst_errs", 64'({launch_err_o, cpl_err_o}), 64'd0);
        rst_i = 1'b0;

        // 1: single launch, latency and completion
        issue_ready_i = 1'b1;
        applyStimulus(1, 3, 64'hA5, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_not_yet", 64'(issue_valid_o), 64'd0);
        step();
        checkOutput("t1_valid", 64'(issue_valid_o), 64'd1);
        checkOutput("t1_warp", 64'(issue_warp_o), 64'd3);
        checkOutput("t1_cmd", issue_cmd_o, 64'hA5);
        step();
        checkOutput("t1_count", 64'(issue_count_o), 64'd1);
        checkOutput("t1_inflight", 64'(inflight_cnt_o), 64'd1);
        checkOutput("t1_busy", 64'(warp_busy_o), 64'h0008);
        checkOutput("t1_valid_low", 64'(issue_valid_o), 64'd0);
        applyStimulus(0, 0, 0, 1, 3);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_busy_clr", 64'(warp_busy_o), 64'd0);
        checkOutput("t1_idle", 64'(idle_o), 64'd1);

        // 2: round-robin order, back-to-back issue, wrap from pointer 9
        hs_log.delete();
        applyStimulus(1, 0, 64'h100, 0, 0);
        step();
        applyStimulus(1, 5, 64'h105, 0, 0);
        step();
        checkOutput("t2_w0", 64'({issue_valid_o, issue_warp_o}), 64'h10);
        applyStimulus(1, 9, 64'h109, 0, 0);
        step();
        checkOutput("t2_w5", 64'({issue_valid_o, issue_warp_o}), 64'h15);
        checkOutput("t2_cmd5", issue_cmd_o, 64'h105);
        applyStimulus(0, 0, 0, 1, 0);
        step();
        checkOutput("t2_w9", 64'({issue_valid_o, issue_warp_o}), 64'h19);
        checkOutput("t2_inflight_bal", 64'(inflight_cnt_o), 64'd1);
        applyStimulus(0, 0, 0, 1, 5);
        step();
        checkOutput("t2_drained", 64'(issue_valid_o), 64'd0);
        applyStimulus(1, 0, 64'h200, 1, 9);
        step();
        checkOutput("t2_inflight0", 64'(inflight_cnt_o), 64'd0);
        applyStimulus(1, 5, 64'h205, 0, 0);
        step();
        checkOutput("t2_re_w0", 64'({issue_valid_o, issue_warp_o}), 64'h10);
        checkOutput("t2_re_cmd0", issue_cmd_o, 64'h200);
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("t2_re_w5", 64'({issue_valid_o, issue_warp_o}), 64'h15);
        step();
        checkOutput("t2_inflight2", 64'(inflight_cnt_o), 64'd2);
        applyStimulus(0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 1, 5);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkLog("t2_order", '{0, 5, 9, 0, 5});
        checkOutput("t2_count", 64'(issue_count_o), 64'd6);
        checkOutput("t2_idle", 64'(idle_o), 64'd1);

        // 3: in-flight cap
        hs_log.delete();
        for (int w = 10; w < 16; w++) begin
            applyStimulus(1, w, 64'(w), 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0);
        step();
        step();
        step();
        checkOutput("t3_hs4", 64'(hs_log.size()), 64'd4);
        checkOutput("t3_valid0", 64'(issue_valid_o), 64'd0);
        checkOutput("t3_inflight4", 64'(inflight_cnt_o), 64'd4);
        checkOutput("t3_busy", 64'(warp_busy_o), 64'hFC00);
        applyStimulus(0, 0, 0, 1, 10);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_no_same_cycle", 64'(issue_valid_o), 64'd0);
        checkOutput("t3_inflight3", 64'(inflight_cnt_o), 64'd3);
        step();
        checkOutput("t3_fifth", 64'({issue_valid_o, issue_warp_o}), 64'h1E);
        step();
        checkOutput("t3_capped_again", 64'({issue_valid_o, 1'b0, inflight_cnt_o}), 64'h4);
        applyStimulus(0, 0, 0, 1, 11);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("t3_sixth", 64'({issue_valid_o, issue_warp_o}), 64'h1F);
        step();
        for (int w = 12; w < 16; w++) begin
            applyStimulus(0, 0, 0, 1, w);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkLog("t3_order", '{10, 11, 12, 13, 14, 15});
        checkOutput("t3_idle", 64'({idle_o, 1'b0, inflight_cnt_o}), 64'h10);

        // 4: backpressure hold and rejected relaunch
        hs_log.delete();
        issue_ready_i = 1'b0;
        applyStimulus(1, 2, 64'h1111, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("t4_present", 64'({issue_valid_o, issue_warp_o}), 64'h12);
        applyStimulus(1, 2, 64'h2222, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_launch_err", 64'(launch_err_o), 64'd1);
        checkOutput("t4_cmd_held0", issue_cmd_o, 64'h1111);
        for (int c = 1; c < 5; c++) begin
            step();
            if (c == 1) checkOutput("t4_err_pulse", 64'(launch_err_o), 64'd0);
            checkOutput($sformatf("t4_hold_%0d", c), 64'({issue_valid_o, issue_warp_o}), 64'h12);
            checkOutput($sformatf("t4_cmd_%0d", c), issue_cmd_o, 64'h1111);
        end
        issue_ready_i = 1'b1;
        step();
        checkLog("t4_hs", '{2});
        checkOutput("t4_after", 64'({issue_valid_o, 1'b0, inflight_cnt_o}), 64'h1);
        checkOutput("t4_count", 64'(issue_count_o), 64'd13);

        // 5: completion errors and same-edge completion/launch
        applyStimulus(0, 0, 0, 1, 7);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_cpl_err", 64'(cpl_err_o), 64'd1);
        checkOutput("t5_inflight", 64'(inflight_cnt_o), 64'd1);
        step();
        checkOutput("t5_cpl_err_pulse", 64'(cpl_err_o), 64'd0);
        applyStimulus(1, 1, 64'h3, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("t5_w1", 64'({issue_valid_o, issue_warp_o}), 64'h11);
        step();
        checkOutput("t5_busy", 64'(warp_busy_o), 64'h0006);
        applyStimulus(1, 1, 64'h3333, 1, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_same_edge_err", 64'(launch_err_o), 64'd1);
        checkOutput("t5_w1_idle", 64'(warp_busy_o), 64'h0004);
        checkOutput("t5_inflight1", 64'(inflight_cnt_o), 64'd1);
        step();
        checkOutput("t5_no_issue", 64'(issue_valid_o), 64'd0);
        applyStimulus(0, 0, 0, 1, 2);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_idle", 64'(idle_o), 64'd1);

        // 6: reset mid-handshake with three warps in flight
        for (int w = 4; w < 8; w++) begin
            applyStimulus(1, w, 64'(w), 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("t6_pre", 64'({issue_valid_o, issue_warp_o, 1'b0, inflight_cnt_o}), 64'h173);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checkOutput("t6_valid", 64'(issue_valid_o), 64'd0);
        checkOutput("t6_idle", 64'(idle_o), 64'd1);
        checkOutput("t6_busy", 64'(warp_busy_o), 64'd0);
        checkOutput("t6_inflight", 64'(inflight_cnt_o), 64'd0);
        checkOutput("t6_count", 64'(issue_count_o), 64'd0);
        checkOutput("t6_warp_cmd", 64'({issue_warp_o, issue_cmd_o[59:0]}), 64'd0);
        checkOutput("t6_errs", 64'({launch_err_o, cpl_err_o}), 64'd0);
        applyStimulus(1, 3, 64'h77, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_latency", 64'(issue_valid_o), 64'd0);
        step();
        checkOutput("t6_issue", 64'({issue_valid_o, issue_warp_o}), 64'h13);
        checkOutput("t6_cmd", issue_cmd_o, 64'h77);
        step();
        checkOutput("t6_count1", 64'(issue_count_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
